lanes_rx_ctrl: RTL and testbench
================================

// Module: lanes_rx_ctrl
// PURPOSE
//  Sequencer for the two-lane RX deserializer. Owns enable_deser and the gen_speed value
//  driven to it. Brings the deserializer up after rx_on, waits for its first valid word,
//  and supervises symbol-boundary pulses (descr_rst). Handles generation-speed changes and
//  retries/failure, and reports rx_ready to the logical-layer receive path.
// PARAMETERS
//  SETTLE_CYCLES  16   cycles enable_deser is held low before (re)enable
//  FIRST_TIMEOUT  512  max cycles in WAIT_FIRST for enable_dec to rise
//  WDOG_CYCLES    256  max cycles between descr_rst pulses while ACTIVE
//  MAX_RETRY      3    consecutive failed bring-ups before FAIL
//  CNT_WIDTH      16   width of sym_count
// PORTS
//  clk             in   1          clock
//  rst             in   1          reset, asynchronous, active-low
//  rx_on           in   1          level; receive path requested
//  gen_speed_req   in   2          requested speed: 00 GEN4, 01 GEN3, 10 GEN2, 11 treated as 00
//  enable_dec      in   1          from deserializer; high once parallel words are valid
//  descr_rst       in   1          from deserializer; one-cycle pulse once per word period
//  enable_deser    out  1          deserializer enable
//  gen_speed       out  2          speed applied to deserializer; changes only while enable_deser=0
//  rx_ready        out  1          high in ACTIVE
//  speed_chg_done  out  1          1-cycle pulse on entering ACTIVE after a speed change
//  retry_err       out  1          1-cycle pulse on each FIRST_TIMEOUT or watchdog expiry
//  link_fail       out  1          high in FAIL
//  sym_count       out  CNT_WIDTH  descr_rst pulses counted in ACTIVE; wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 (gen_speed=00). Internal counters and retry count are 0.
//  - All outputs are registered and update on the same edge as the state.
//  - States: IDLE, SETTLE, WAIT_FIRST, ACTIVE, FAIL.
//  - IDLE: enable_deser=0.
//    - rx_on=1 -> SETTLE; gen_speed<=normalised gen_speed_req (11->00).
//  - SETTLE: enable_deser=0; counts SETTLE_CYCLES cycles, then -> WAIT_FIRST.
//    - If gen_speed_req changes here: relatch gen_speed and restart the settle count.
//  - WAIT_FIRST: enable_deser=1; timer runs from 0.
//    - enable_dec=1 -> ACTIVE; retry count cleared.
//    - Timer reaches FIRST_TIMEOUT-1 -> retry_err pulse; retry+1.
//      Then -> SETTLE if retry<MAX_RETRY, else -> FAIL.
//  - ACTIVE: enable_deser=1, rx_ready=1.
//    - sym_count increments on each descr_rst.
//    - Watchdog clears on each descr_rst. Reaching WDOG_CYCLES-1 -> retry_err pulse, -> SETTLE,
//      retry+1 (-> FAIL if limit reached).
//    - enable_dec falling while ACTIVE is treated like a watchdog expiry.
//  - Speed change: in ACTIVE or WAIT_FIRST, gen_speed_req != gen_speed -> SETTLE.
//    - enable_deser drops the next cycle; gen_speed is relatched on the same edge.
//    - A change flag is set; speed_chg_done pulses on the next ACTIVE entry, then the flag clears.
//    - Speed change does not count as a retry.
//  - rx_on=0 in any state -> IDLE next cycle. Clears retry, flag, sym_count, link_fail.
//    This has priority over every other transition.
//  - FAIL: enable_deser=0, link_fail=1; left only via rx_on=0.
//  - sym_count clears on leaving ACTIVE.
//  - Simultaneous events, priority order:
//    1. rx_on=0
//    2. speed change
//    3. enable_dec/descr_rst progress
//    4. timer expiry
//    - descr_rst on the same cycle as watchdog expiry counts as progress (no error).
//  - Async reset mid-operation: immediately returns to reset values; no pulse outputs emitted.
// TESTING
//  1. Bring-up GEN4: reset, rx_on=1, req=00, deser model raises enable_dec 9 cycles after enable ->
//     enable_deser=1 after 16 SETTLE cycles; rx_ready=1 one cycle after enable_dec; retry_err never.
//  2. Timeout/FAIL: enable_dec held 0 -> 3 retry_err pulses, each 512 cycles after entering
//     WAIT_FIRST; link_fail=1; enable_deser=0.
//     Then rx_on=0 -> IDLE, link_fail=0.
//  3. Speed change: ACTIVE at GEN4, req 00->01 -> enable_deser=0 next cycle, gen_speed=01 while
//     enable low; re-enable after 16 cycles; enable_dec at +133 -> ACTIVE; speed_chg_done one pulse.
//  4. Watchdog: ACTIVE, descr_rst stops -> retry_err at 256 cycles; back to SETTLE; sym_count=0.
//     A descr_rst exactly on cycle 255 -> no error.
//  5. sym_count: CNT_WIDTH=4, 20 descr_rst pulses in ACTIVE -> sym_count=4 (wrap).
//     req=11 -> gen_speed=00.
//  6. Async reset asserted in ACTIVE mid-word -> all outputs 0 immediately; after release, rx_on=1
//     repeats scenario 1 timing.

Source files
------------

// File: rtl/lanes_rx_ctrl.sv
// Sequencer for the two-lane RX deserializer.
// Brings the deserializer up after rx_on, waits for its first valid word, supervises
// descr_rst symbol-boundary pulses with a watchdog, handles generation-speed changes,
// retries failed bring-ups and latches a link failure after MAX_RETRY in a row.
module lanes_rx_ctrl #(
    parameter int SETTLE_CYCLES = 16,
    parameter int FIRST_TIMEOUT = 512,
    parameter int WDOG_CYCLES   = 256,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_on,
    input  logic [1:0]           gen_speed_req,
    input  logic                 enable_dec,
    input  logic                 descr_rst,
    output logic                 enable_deser,
    output logic [1:0]           gen_speed,
    output logic                 rx_ready,
    output logic                 speed_chg_done,
    output logic                 retry_err,
    output logic                 link_fail,
    output logic [CNT_WIDTH-1:0] sym_count
);

    // One shared timer serves the settle count, the first-word timeout and the watchdog,
    // so it must be wide enough for the longest of the three.
    localparam int T_MAX = (SETTLE_CYCLES > FIRST_TIMEOUT)
                         ? ((SETTLE_CYCLES > WDOG_CYCLES) ? SETTLE_CYCLES : WDOG_CYCLES)
                         : ((FIRST_TIMEOUT > WDOG_CYCLES) ? FIRST_TIMEOUT : WDOG_CYCLES);
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int RW    = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        WAIT_FIRST,
        ACTIVE,
        FAIL
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [RW-1:0]   retry_cnt;
    logic            chg_flag;

    logic [1:0]      req_norm;
    logic            speed_diff;
    logic            retry_last;

    // Speed code 11 is not a real generation; it maps onto GEN4 (00).
    assign req_norm   = (gen_speed_req == 2'b11) ? 2'b00 : gen_speed_req;
    assign speed_diff = (req_norm != gen_speed);
    // This failure is the one that exhausts the retry budget.
    assign retry_last = (retry_cnt >= RW'(MAX_RETRY - 1));

    // Sequencer state, timer, retry bookkeeping and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            timer          <= '0;
            retry_cnt      <= '0;
            chg_flag       <= 1'b0;
            enable_deser   <= 1'b0;
            gen_speed      <= 2'b00;
            rx_ready       <= 1'b0;
            speed_chg_done <= 1'b0;
            retry_err      <= 1'b0;
            link_fail      <= 1'b0;
            sym_count      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only; the pulse outputs
            // get a default of 0 here and are overridden below on the single cycle they fire.
            speed_chg_done <= 1'b0;
            retry_err      <= 1'b0;

            if (!rx_on) begin
                // Dropping rx_on wins over every other event in every state.
                state        <= IDLE;
                timer        <= '0;
                retry_cnt    <= '0;
                chg_flag     <= 1'b0;
                enable_deser <= 1'b0;
                rx_ready     <= 1'b0;
                link_fail    <= 1'b0;
                sym_count    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= SETTLE;
                        gen_speed <= req_norm;
                        timer     <= '0;
                    end

                    SETTLE: begin
                        if (speed_diff) begin
                            // Deserializer is still disabled, so the new speed can be
                            // applied directly; settle time starts over.
                            gen_speed <= req_norm;
                            timer     <= '0;
                        end else if (timer == TW'(SETTLE_CYCLES - 1)) begin
                            state        <= WAIT_FIRST;
                            enable_deser <= 1'b1;
                            timer        <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end

                    WAIT_FIRST: begin
                        if (speed_diff) begin
                            state        <= SETTLE;
                            enable_deser <= 1'b0;
                            gen_speed    <= req_norm;
                            chg_flag     <= 1'b1;
                            timer        <= '0;
                        end else if (enable_dec) begin
                            state          <= ACTIVE;
                            rx_ready       <= 1'b1;
                            retry_cnt      <= '0;
                            speed_chg_done <= chg_flag;
                            chg_flag       <= 1'b0;
                            sym_count      <= '0;
                            timer          <= '0;
                        end else if (timer == TW'(FIRST_TIMEOUT - 1)) begin
                            retry_err    <= 1'b1;
                            retry_cnt    <= retry_cnt + 1'b1;
                            enable_deser <= 1'b0;
                            timer        <= '0;
                            if (retry_last) begin
                                state     <= FAIL;
                                link_fail <= 1'b1;
                            end else begin
                                state <= SETTLE;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end

                    ACTIVE: begin
                        if (speed_diff) begin
                            state        <= SETTLE;
                            enable_deser <= 1'b0;
                            rx_ready     <= 1'b0;
                            gen_speed    <= req_norm;
                            chg_flag     <= 1'b1;
                            sym_count    <= '0;
                            timer        <= '0;
                        end else if (descr_rst) begin
                            // A boundary pulse on the expiry cycle still counts as progress.
                            sym_count <= sym_count + 1'b1;
                            timer     <= '0;
                        end else if (!enable_dec || (timer == TW'(WDOG_CYCLES - 1))) begin
                            // Lost word alignment or silent deserializer: retry from settle.
                            retry_err    <= 1'b1;
                            retry_cnt    <= retry_cnt + 1'b1;
                            enable_deser <= 1'b0;
                            rx_ready     <= 1'b0;
                            sym_count    <= '0;
                            timer        <= '0;
                            if (retry_last) begin
                                state     <= FAIL;
                                link_fail <= 1'b1;
                            end else begin
                                state <= SETTLE;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end

                    FAIL: begin
                        // Held here until rx_on is withdrawn.
                        enable_deser <= 1'b0;
                        link_fail    <= 1'b1;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lanes_rx_ctrl.sv
// Directed testbench for lanes_rx_ctrl. Inputs are driven and outputs sampled on the
// falling clock edge; the DUT uses CNT_WIDTH=4 so the sym_count wrap is reachable.
module tb_lanes_rx_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_on;
    logic [1:0]    gen_speed_req;
    logic          enable_dec;
    logic          descr_rst;
    logic          enable_deser;
    logic [1:0]    gen_speed;
    logic          rx_ready;
    logic          speed_chg_done;
    logic          retry_err;
    logic          link_fail;
    logic [CW-1:0] sym_count;

    int n_cmp = 0;
    int n_bad = 0;
    int err_pulses = 0;
    int chg_pulses = 0;

    lanes_rx_ctrl #(
        .SETTLE_CYCLES (16),
        .FIRST_TIMEOUT (512),
        .WDOG_CYCLES   (256),
        .MAX_RETRY     (3),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_on          (rx_on),
        .gen_speed_req  (gen_speed_req),
        .enable_dec     (enable_dec),
        .descr_rst      (descr_rst),
        .enable_deser   (enable_deser),
        .gen_speed      (gen_speed),
        .rx_ready       (rx_ready),
        .speed_chg_done (speed_chg_done),
        .retry_err      (retry_err),
        .link_fail      (link_fail),
        .sym_count      (sym_count)
    );

    always #5 clk = ~clk;

    // Pulse tally, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (retry_err === 1'b1) err_pulses++;
        if (speed_chg_done === 1'b1) chg_pulses++;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b0; rx_on = 1'b1; gen_speed_req = 2'b01; enable_dec = 1'b0; descr_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({enable_deser, gen_speed, rx_ready, speed_chg_done, retry_err, link_fail, sym_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {enable_deser, gen_speed, rx_ready, speed_chg_done, retry_err, link_fail, sym_count});
        end
        rx_on = 1'b0; gen_speed_req = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({enable_deser, gen_speed, rx_ready, link_fail, sym_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_release_idle: got %h required 0",
                     {enable_deser, gen_speed, rx_ready, link_fail, sym_count});
        end
    endtask

    // Scenario 1: GEN4 bring-up from IDLE, enable_dec raised 9 edges after enable.
    task automatic test_bringup(input string tag);
        int e0;
        e0 = err_pulses;
        @(negedge clk);
        gen_speed_req = 2'b00; rx_on = 1'b1;
        repeat (16) @(negedge clk);
        n_cmp++;
        if (enable_deser !== 1'b0) begin
            n_bad++;
            $display("FAIL %s settle_low: enable_deser got %b required 0", tag, enable_deser);
        end
        @(negedge clk);
        n_cmp++;
        if (enable_deser !== 1'b1) begin
            n_bad++;
            $display("FAIL %s enable_after_16: enable_deser got %b required 1", tag, enable_deser);
        end
        repeat (8) @(negedge clk);
        n_cmp++;
        if (rx_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s ready_early: rx_ready got %b required 0", tag, rx_ready);
        end
        enable_dec = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rx_ready, speed_chg_done, gen_speed} !== 4'b1000) begin
            n_bad++;
            $display("FAIL %s ready: {rx_ready,chg_done,gen_speed} got %b required 1000",
                     tag, {rx_ready, speed_chg_done, gen_speed});
        end
        n_cmp++;
        if (err_pulses !== e0) begin
            n_bad++;
            $display("FAIL %s no_retry: retry_err pulses got %0d required 0", tag, err_pulses - e0);
        end
    endtask

    // Scenario 3: speed change GEN4 -> GEN3 while ACTIVE.
    task automatic test_speed_change();
        int e0, c0;
        e0 = err_pulses; c0 = chg_pulses;
        @(negedge clk);
        gen_speed_req = 2'b01;
        @(negedge clk);
        n_cmp++;
        if ({enable_deser, gen_speed, rx_ready} !== 4'b0010) begin
            n_bad++;
            $display("FAIL chg_drop: {enable_deser,gen_speed,rx_ready} got %b required 0010",
                     {enable_deser, gen_speed, rx_ready});
        end
        enable_dec = 1'b0;
        repeat (15) @(negedge clk);
        n_cmp++;
        if ({enable_deser, gen_speed} !== 3'b001) begin
            n_bad++;
            $display("FAIL chg_settle: {enable_deser,gen_speed} got %b required 001", {enable_deser, gen_speed});
        end
        @(negedge clk);
        n_cmp++;
        if (enable_deser !== 1'b1) begin
            n_bad++;
            $display("FAIL chg_reenable: enable_deser got %b required 1", enable_deser);
        end
        repeat (132) @(negedge clk);
        n_cmp++;
        if ({rx_ready, retry_err} !== 2'b00) begin
            n_bad++;
            $display("FAIL chg_wait: {rx_ready,retry_err} got %b required 00", {rx_ready, retry_err});
        end
        enable_dec = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rx_ready, speed_chg_done, gen_speed} !== 4'b1101) begin
            n_bad++;
            $display("FAIL chg_done: {rx_ready,chg_done,gen_speed} got %b required 1101",
                     {rx_ready, speed_chg_done, gen_speed});
        end
        @(negedge clk);
        n_cmp++;
        if (speed_chg_done !== 1'b0) begin
            n_bad++;
            $display("FAIL chg_done_width: speed_chg_done got %b required 0", speed_chg_done);
        end
        n_cmp++;
        if ((chg_pulses - c0) !== 1 || (err_pulses - e0) !== 0) begin
            n_bad++;
            $display("FAIL chg_counts: chg pulses %0d err pulses %0d required 1 and 0",
                     chg_pulses - c0, err_pulses - e0);
        end
    endtask

    // Scenario 4: boundary pulse on watchdog cycle 255 is progress; silence then expires.
    task automatic test_watchdog();
        int e0;
        e0 = err_pulses;
        @(negedge clk);
        descr_rst = 1'b1;
        @(negedge clk);
        descr_rst = 1'b0;
        repeat (255) @(negedge clk);
        descr_rst = 1'b1;
        @(negedge clk);
        descr_rst = 1'b0;
        n_cmp++;
        if ({retry_err, rx_ready, sym_count} !== {2'b01, 4'd2}) begin
            n_bad++;
            $display("FAIL wdog_edge_pulse: {retry_err,rx_ready,sym_count} got %b required 01_0010",
                     {retry_err, rx_ready, sym_count});
        end
        repeat (255) @(negedge clk);
        n_cmp++;
        if (retry_err !== 1'b0 || (err_pulses - e0) !== 0) begin
            n_bad++;
            $display("FAIL wdog_early: retry_err %b pulses %0d required 0 and 0", retry_err, err_pulses - e0);
        end
        @(negedge clk);
        n_cmp++;
        if ({retry_err, rx_ready, enable_deser, sym_count} !== {3'b100, 4'd0}) begin
            n_bad++;
            $display("FAIL wdog_expire: {retry_err,rx_ready,enable_deser,sym_count} got %b required 100_0000",
                     {retry_err, rx_ready, enable_deser, sym_count});
        end
        enable_dec = 1'b0;
    endtask

    // Scenario 2: enable_dec never rises -> three timeouts, then FAIL until rx_on drops.
    task automatic test_timeout_fail();
        int e0, t;
        @(negedge clk);
        rx_on = 1'b0; enable_dec = 1'b0; gen_speed_req = 2'b00;
        @(negedge clk);
        e0 = err_pulses;
        rx_on = 1'b1;
        for (int r = 0; r < 3; r++) begin
            t = 0;
            while (enable_deser !== 1'b1 && t < 100) begin
                @(negedge clk);
                t++;
            end
            n_cmp++;
            if (enable_deser !== 1'b1) begin
                n_bad++;
                $display("FAIL to_enable_%0d: enable_deser got %b required 1 within 100 cycles", r, enable_deser);
            end
            repeat (511) @(negedge clk);
            n_cmp++;
            if (retry_err !== 1'b0) begin
                n_bad++;
                $display("FAIL to_early_%0d: retry_err got %b required 0", r, retry_err);
            end
            @(negedge clk);
            n_cmp++;
            if ({retry_err, enable_deser, link_fail} !== {2'b10, (r == 2)}) begin
                n_bad++;
                $display("FAIL to_expire_%0d: {retry_err,enable_deser,link_fail} got %b required %b",
                         r, {retry_err, enable_deser, link_fail}, {2'b10, (r == 2)});
            end
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if ({link_fail, enable_deser, rx_ready, retry_err} !== 4'b1000 || (err_pulses - e0) !== 3) begin
            n_bad++;
            $display("FAIL fail_hold: {link_fail,enable_deser,rx_ready,retry_err} got %b pulses %0d required 1000 and 3",
                     {link_fail, enable_deser, rx_ready, retry_err}, err_pulses - e0);
        end
        rx_on = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({link_fail, enable_deser} !== 2'b00) begin
            n_bad++;
            $display("FAIL fail_exit: {link_fail,enable_deser} got %b required 00", {link_fail, enable_deser});
        end
    endtask

    // Scenario 5: req 11 normalises to 00 (relatch restarts settle), then sym_count wraps.
    task automatic test_sym_wrap();
        @(negedge clk);
        gen_speed_req = 2'b10; rx_on = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (gen_speed !== 2'b10) begin
            n_bad++;
            $display("FAIL latch_gen2: gen_speed got %b required 10", gen_speed);
        end
        repeat (4) @(negedge clk);
        gen_speed_req = 2'b11;
        @(negedge clk);
        n_cmp++;
        if ({gen_speed, enable_deser} !== 3'b000) begin
            n_bad++;
            $display("FAIL req11_norm: {gen_speed,enable_deser} got %b required 000", {gen_speed, enable_deser});
        end
        repeat (15) @(negedge clk);
        n_cmp++;
        if (enable_deser !== 1'b0) begin
            n_bad++;
            $display("FAIL relatch_restart: enable_deser got %b required 0", enable_deser);
        end
        @(negedge clk);
        n_cmp++;
        if (enable_deser !== 1'b1) begin
            n_bad++;
            $display("FAIL relatch_enable: enable_deser got %b required 1", enable_deser);
        end
        repeat (3) @(negedge clk);
        enable_dec = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            descr_rst = 1'b1;
            @(negedge clk);
            descr_rst = 1'b0;
            @(negedge clk);
            if (i == 15) begin
                n_cmp++;
                if (sym_count !== 4'd0) begin
                    n_bad++;
                    $display("FAIL sym_wrap16: sym_count got %0d required 0", sym_count);
                end
            end
        end
        n_cmp++;
        if ({rx_ready, sym_count} !== {1'b1, 4'd4}) begin
            n_bad++;
            $display("FAIL sym_count20: {rx_ready,sym_count} got %b required 1_0100", {rx_ready, sym_count});
        end
    endtask

    // Scenario 6: asynchronous reset in ACTIVE, then a fresh bring-up.
    task automatic test_async_reset();
        @(negedge clk);
        descr_rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({enable_deser, gen_speed, rx_ready, speed_chg_done, retry_err, link_fail, sym_count} !== '0) begin
            n_bad++;
            $display("FAIL async_reset_now: got %h required 0",
                     {enable_deser, gen_speed, rx_ready, speed_chg_done, retry_err, link_fail, sym_count});
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({enable_deser, rx_ready, speed_chg_done, retry_err, sym_count} !== '0) begin
            n_bad++;
            $display("FAIL async_reset_hold: got %h required 0",
                     {enable_deser, rx_ready, speed_chg_done, retry_err, sym_count});
        end
        descr_rst = 1'b0; enable_dec = 1'b0; rx_on = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        test_bringup("after_reset");
    endtask

    initial begin
        test_reset();
        test_bringup("gen4");
        test_speed_change();
        test_watchdog();
        test_timeout_fail();
        test_sym_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
